// File: rtl/sdr_init_sequencer_pkg.sv
// Shared definitions for the SDR SDRAM power-up sequencer.
//   - state_e : sequencer states. The DONE_* states are reached only when
//               SDR_INIT_PERIODIC_REFRESH_EN is defined.
//   - cmd_t   : SDRAM command nibble {cs_n, ras_n, cas_n, we_n}.
//   - SDR_ADDR_W / SDR_BA_W : widths of the address and bank buses.
package sdr_pkg;

    localparam int SDR_ADDR_W = 13;
    localparam int SDR_BA_W   = 2;

    typedef enum logic [3:0] {
        ST_HOLD,
        ST_POWERUP,
        ST_PRE,
        ST_WAIT_RP,
        ST_REF,
        ST_WAIT_RFC,
        ST_LMR,
        ST_WAIT_MRD,
        ST_DONE,
        ST_DONE_REQ,   // refresh requested, waiting for grant
        ST_DONE_REF,   // one-cycle AUTO REFRESH after grant
        ST_DONE_RFC    // bus held in NOP while the refresh completes
    } state_e;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_NOP = 4'b0111;
    localparam cmd_t CMD_PRE = 4'b0010;
    localparam cmd_t CMD_REF = 4'b0001;
    localparam cmd_t CMD_LMR = 4'b0000;
    localparam cmd_t CMD_INH = 4'b1111;

endpackage

// File: rtl/sdr_init_sequencer_if.sv
// SDRAM command bus owned by the init sequencer until o_init_done.
//   master : the sequencer (drives CKE, command pins, address, bank,
//            o_init_done, o_ref_req; samples i_ref_gnt)
//   slave  : the controller/mux side (the reverse directions)
interface sdr_init_sequencer_if;
    import sdr_pkg::*;

    logic                  o_sdr_cke;
    logic                  o_sdr_cs_n;
    logic                  o_sdr_ras_n;
    logic                  o_sdr_cas_n;
    logic                  o_sdr_we_n;
    logic [SDR_ADDR_W-1:0] o_sdr_addr;
    logic [SDR_BA_W-1:0]   o_sdr_ba;
    logic                  o_init_done;
    logic                  o_ref_req;
    logic                  i_ref_gnt;

    modport master (
        output o_sdr_cke, o_sdr_cs_n, o_sdr_ras_n, o_sdr_cas_n, o_sdr_we_n,
        output o_sdr_addr, o_sdr_ba, o_init_done, o_ref_req,
        input  i_ref_gnt
    );

    modport slave (
        input  o_sdr_cke, o_sdr_cs_n, o_sdr_ras_n, o_sdr_cas_n, o_sdr_we_n,
        input  o_sdr_addr, o_sdr_ba, o_init_done, o_ref_req,
        output i_ref_gnt
    );

endinterface

// File: rtl/sdr_init_sequencer_sync2.sv
// Two-flop level synchronizer.
//   i_clk  : destination clock
//   i_rst  : asynchronous active-high reset, forces both flops to RST_VAL
//   i_d    : asynchronous level input
//   o_q    : synchronized level, two i_clk edges behind i_d
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_d};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/sdr_init_sequencer.sv
// JEDEC SDR SDRAM power-up sequencer: CKE enable, power-up wait,
// PRECHARGE ALL, NUM_REFRESH x AUTO REFRESH, LOAD MODE REGISTER, then
// o_init_done. Command spacing after PRE/REF/LMR is T_x+1 clocks.
//   i_brd_clk : board clock
//   i_brd_rst : asynchronous active-high reset
//   i_sdr_rst : SDRAM hold-off level from the clock/reset generator
//               (foreign domain, synchronized internally)
//   sdr       : command bus (master side), see sdr_init_sequencer_if
// Optional: define SDR_INIT_PERIODIC_REFRESH_EN to issue periodic AUTO
// REFRESH after init via the o_ref_req / i_ref_gnt handshake. Without it
// o_ref_req is tied low and i_ref_gnt is ignored.
module sdr_init_sequencer
    import sdr_pkg::*;
#(
    parameter int                    T_INIT_CYC  = 5000,
    parameter int                    T_RP        = 2,
    parameter int                    T_RFC       = 7,
    parameter int                    T_MRD       = 2,
    parameter int                    NUM_REFRESH = 2,
    parameter logic [SDR_ADDR_W-1:0] MODE_REG    = 13'h023,
    parameter int                    T_REFI      = 390
) (
    input  logic                 i_brd_clk,
    input  logic                 i_brd_rst,
    input  logic                 i_sdr_rst,
    sdr_init_sequencer_if.master sdr
);

    localparam logic [15:0] INIT_LOAD = 16'(T_INIT_CYC - 1);
    localparam logic [15:0] RP_LOAD   = 16'(T_RP - 1);
    localparam logic [15:0] RFC_LOAD  = 16'(T_RFC - 1);
    localparam logic [15:0] MRD_LOAD  = 16'(T_MRD - 1);
    localparam logic [15:0] REFI_LOAD = 16'(T_REFI - 1);
    localparam logic [3:0]  REF_LOAD  = 4'(NUM_REFRESH);

    logic sdr_rst_s;

    sync2 #(.RST_VAL(1'b1)) u_sync_sdr_rst (
        .i_clk (i_brd_clk),
        .i_rst (i_brd_rst),
        .i_d   (i_sdr_rst),
        .o_q   (sdr_rst_s)
    );

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [3:0]            rcnt_q, rcnt_d;
    cmd_t                  cmd_q, cmd_d;
    logic                  cke_q, cke_d;
    logic [SDR_ADDR_W-1:0] addr_q, addr_d;
    logic [SDR_BA_W-1:0]   ba_q, ba_d;
    logic                  done_q, done_d;
    logic                  ref_req_q, ref_req_d;
    logic                  cnt_zero;

    assign cnt_zero = (cnt_q == 16'd0);

    // Next state and counters. Wait states only decrement while nonzero,
    // so the counter can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_HOLD: begin
                state_d = ST_POWERUP;
                cnt_d   = INIT_LOAD;
            end
            ST_POWERUP: begin
                if (cnt_zero) state_d = ST_PRE;
                else          cnt_d   = cnt_q - 16'd1;
            end
            ST_PRE: begin
                state_d = ST_WAIT_RP;
                cnt_d   = RP_LOAD;
            end
            ST_WAIT_RP: begin
                if (cnt_zero) begin
                    state_d = ST_REF;
                    rcnt_d  = REF_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_REF: begin
                state_d = ST_WAIT_RFC;
                cnt_d   = RFC_LOAD;
                rcnt_d  = rcnt_q - 4'd1;
            end
            ST_WAIT_RFC: begin
                if (cnt_zero) state_d = (rcnt_q != 4'd0) ? ST_REF : ST_LMR;
                else          cnt_d   = cnt_q - 16'd1;
            end
            ST_LMR: begin
                state_d = ST_WAIT_MRD;
                cnt_d   = MRD_LOAD;
            end
            ST_WAIT_MRD: begin
                // The refresh-interval count is preloaded on entry to DONE;
                // it is simply left idle when periodic refresh is disabled.
                if (cnt_zero) begin
                    state_d = ST_DONE;
                    cnt_d   = REFI_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef SDR_INIT_PERIODIC_REFRESH_EN
            ST_DONE: begin
                if (cnt_zero) state_d = ST_DONE_REQ;
                else          cnt_d   = cnt_q - 16'd1;
            end
            ST_DONE_REQ: begin
                if (sdr.i_ref_gnt) state_d = ST_DONE_REF;
            end
            ST_DONE_REF: begin
                state_d = ST_DONE_RFC;
                cnt_d   = RFC_LOAD;
            end
            ST_DONE_RFC: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                    cnt_d   = REFI_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`else
            ST_DONE: begin
                state_d = ST_DONE;
            end
`endif
            default: begin
                state_d = ST_HOLD;
                cnt_d   = 16'd0;
                rcnt_d  = 4'd0;
            end
        endcase
        // Hold-off overrides everything, including the HOLD exit above.
        if (sdr_rst_s) begin
            state_d = ST_HOLD;
            cnt_d   = 16'd0;
            rcnt_d  = 4'd0;
        end
    end

    // Outputs are decoded from the next state so each registered pin lines
    // up with the state it belongs to; a command state lasts one cycle, so
    // each command is on the bus for exactly one clock.
    always_comb begin
        cke_d     = 1'b1;
        cmd_d     = CMD_NOP;
        addr_d    = '0;
        ba_d      = '0;
        done_d    = 1'b0;
        ref_req_d = 1'b0;
        case (state_d)
            ST_HOLD: begin
                cke_d = 1'b0;
                cmd_d = CMD_INH;
            end
            ST_PRE: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
            end
            ST_REF:      cmd_d = CMD_REF;
            ST_LMR: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            ST_DONE:     done_d = 1'b1;
            ST_DONE_REQ: begin
                done_d    = 1'b1;
                ref_req_d = 1'b1;
            end
            ST_DONE_REF: begin
                done_d = 1'b1;
                cmd_d  = CMD_REF;
            end
            ST_DONE_RFC: done_d = 1'b1;
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
        if (i_brd_rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= 16'd0;
            rcnt_q    <= 4'd0;
            cmd_q     <= CMD_INH;
            cke_q     <= 1'b0;
            addr_q    <= '0;
            ba_q      <= '0;
            done_q    <= 1'b0;
            ref_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            cmd_q     <= cmd_d;
            cke_q     <= cke_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
            done_q    <= done_d;
            ref_req_q <= ref_req_d;
        end
    end

    assign sdr.o_sdr_cke   = cke_q;
    assign sdr.o_sdr_cs_n  = cmd_q[3];
    assign sdr.o_sdr_ras_n = cmd_q[2];
    assign sdr.o_sdr_cas_n = cmd_q[1];
    assign sdr.o_sdr_we_n  = cmd_q[0];
    assign sdr.o_sdr_addr  = addr_q;
    assign sdr.o_sdr_ba    = ba_q;
    assign sdr.o_init_done = done_q;

`ifdef SDR_INIT_PERIODIC_REFRESH_EN
    assign sdr.o_ref_req = ref_req_q;
`else
    // The request state is unreachable here; keep the pin hard low.
    logic unused_ref;
    assign unused_ref    = ref_req_q ^ sdr.i_ref_gnt;
    assign sdr.o_ref_req = 1'b0;
`endif

endmodule

// File: doc/sdr_init_sequencer.md
Name: sdr_init_sequencer

Overview:
- Downstream consumer of the board clock/reset generator's SDRAM reset (o_sdr_rst).
- Performs the JEDEC SDR SDRAM power-up sequence on the board clock: CKE enable, stable wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
- Raises o_init_done, which feeds the generator's i_memory_initialized.
- Owns the SDRAM command pins until done; afterwards the SDRAM controller muxes its own commands in when o_init_done=1.

Parameters:
- T_INIT_CYC, 5000: power-up wait in clocks (100 us at 50 MHz); range 1..65535.
- T_RP, 2: clocks from PRECHARGE to next command; >=1.
- T_RFC, 7: clocks from AUTO REFRESH to next command; >=1.
- T_MRD, 2: clocks from LOAD MODE to o_init_done; >=1.
- NUM_REFRESH, 2: AUTO REFRESH commands issued; 1..15.
- MODE_REG, 13'h023: mode word (CL=2, sequential, burst 8).
- T_REFI, 390: refresh interval in clocks; used only with the optional feature.

Ports:
- i_brd_clk  in  1  board clock
- i_brd_rst  in  1  board reset
- i_sdr_rst  in  1  SDRAM hold-off from clock/reset generator; level, foreign domain
- o_sdr_cke  out  1  SDRAM clock enable
- o_sdr_cs_n, o_sdr_ras_n, o_sdr_cas_n, o_sdr_we_n  out  1 each  command pins
- o_sdr_addr  out  13  address / mode word
- o_sdr_ba  out  2  bank address
- o_init_done  out  1  init complete, level
- o_ref_req  out  1  refresh request (optional feature only)
- i_ref_gnt  in  1  refresh grant (optional feature only)

Behaviour:
- Reset is i_brd_rst, asynchronous, active-high; clock is i_brd_clk. All outputs are registered.
- Reset values:
  - cke=0
  - cs_n=1, ras_n=1, cas_n=1, we_n=1 (INHIBIT)
  - addr=0, ba=0
  - o_init_done=0, o_ref_req=0
  - state=HOLD, counter=0
- i_sdr_rst passes through a 2-flop synchronizer (sdr_rst_s); the rest of the logic sees it 2 cycles late.
- Command encodings {cs_n,ras_n,cas_n,we_n}:
  - NOP = 0111
  - PRECHARGE = 0010 (addr[10]=1, all banks)
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000 (addr=MODE_REG, ba=0)
  - Each command lasts exactly 1 cycle; NOP is driven otherwise once cke=1.
- States (16-bit down counter cnt, 4-bit refresh counter rcnt):
  - HOLD: cke=0, INHIBIT. Exits to POWERUP when sdr_rst_s=0, loading cnt=T_INIT_CYC-1.
  - POWERUP: cke=1, NOP. At cnt==0 -> PRE.
  - PRE: issue PRECHARGE, load cnt=T_RP-1 -> WAIT_RP.
  - WAIT_RP: NOP until cnt==0 -> REF, with rcnt=NUM_REFRESH.
  - REF: issue AUTO REFRESH, load cnt=T_RFC-1, decrement rcnt -> WAIT_RFC.
  - WAIT_RFC: at cnt==0 go to REF if rcnt!=0, else LMR.
  - LMR: issue LOAD MODE, load cnt=T_MRD-1 -> WAIT_MRD.
  - WAIT_MRD: at cnt==0 -> DONE.
  - DONE: o_init_done=1, NOP, cke=1.
- A T_x value of 1 means the WAIT state lasts 1 cycle, so the next command comes T_x+1 cycles later. Command spacing is therefore exactly T_x+1 clocks.
- sdr_rst_s=1 in any state: next state is HOLD; cke and o_init_done drop on the next edge, INHIBIT driven, counters cleared.
- Async i_brd_rst mid-sequence: immediate reset values.
- cnt decrements by 1 per cycle in wait states and never wraps; 0 is terminal for the state.

Optional Feature:
- Macro: SDR_INIT_PERIODIC_REFRESH_EN.
- Enabled:
  - In DONE, a refresh-interval counter reloads T_REFI-1 and decrements each cycle.
  - At 0, o_ref_req=1 and stays high until i_ref_gnt=1.
  - The cycle after the grant, the block issues 1 AUTO REFRESH and drops o_ref_req.
  - It then holds NOP for T_RFC cycles (controller must not drive), then reloads the counter.
  - i_ref_gnt while o_ref_req=0 is ignored.
- Disabled: o_ref_req is tied 0 and i_ref_gnt is unused. DONE is static.

Decomposition:
- Package sdr_pkg holds:
  - the state enum
  - command encoding constants (CMD_NOP, CMD_PRE, CMD_REF, CMD_LMR, CMD_INH)
  - SDR_ADDR_W=13, SDR_BA_W=2
- One sub-module: sync2 (2-flop level synchronizer) for i_sdr_rst, reusable elsewhere.

Test Plan (T_INIT_CYC=10, T_RP=2, T_RFC=7, T_MRD=2, NUM_REFRESH=2, T_REFI=20):
- Test 1 — reset only: i_brd_rst=1, i_sdr_rst=1 -> cke=0, INHIBIT, o_init_done=0 indefinitely.
- Test 2 — nominal sequence: release i_sdr_rst at cycle 0 -> expected timeline:
  - cke rises at cycle 3
  - PRECHARGE at 13, addr[10]=1
  - AUTO REFRESH at 16 and 24
  - LOAD MODE at 32, addr=0x023
  - o_init_done=1 at 35
  - exactly 4 non-NOP commands in total
- Test 3 — mid-sequence re-reset: reassert i_sdr_rst at cycle 20 -> cke=0 and INHIBIT by cycle 23. Release again -> full sequence restarts from POWERUP with identical spacing.
- Test 4 — async reset: i_brd_rst pulse in WAIT_RFC -> outputs take reset values in the same cycle with no clock edge; no LOAD MODE issued.
- Test 5 — optional refresh (macro on): after done, o_ref_req rises 20 cycles later. Delay grant 5 cycles -> AUTO REFRESH 1 cycle after the grant, o_ref_req low, no command for the next 7 cycles.
- Test 6 — optional feature off: o_ref_req stays 0 for 1000 cycles after done; toggling i_ref_gnt -> no commands.
